// File: rtl/ecc_defs.sv
// rtl/ecc_defs.sv - shared secp256k1 field constants and sequencer state encoding
package ecc_defs;

  localparam int ECC_WIDTH = 256;
  localparam logic [ECC_WIDTH-1:0] ECC_P =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ecc_state_e;

endpackage

// File: rtl/mod_add_red.sv
// rtl/mod_add_red.sv - combinational (x + y) mod P for x, y < P
module mod_add_red
  import ecc_defs::*;
#(
  parameter int               WIDTH = ECC_WIDTH,
  parameter logic [WIDTH-1:0] P     = ECC_P
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] s_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sum_red;

  // Carry bit is kept so the compare sees the full sum before reduction.
  assign sum     = {1'b0, x_i} + {1'b0, y_i};
  assign sum_red = sum - {1'b0, P};
  assign s_o     = (sum >= {1'b0, P}) ? sum_red[WIDTH-1:0] : sum[WIDTH-1:0];

endmodule

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - bit-serial interleaved modular multiplier R = A*B mod P
// Optional MOD_MUL_SKIP_ZERO_EN starts the scan at the most-significant 1 of B.
module mod_mul_serial
  import ecc_defs::*;
#(
  parameter int               WIDTH = ECC_WIDTH,
  parameter logic [WIDTH-1:0] P     = ECC_P
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R
);

  localparam int IW = $clog2(WIDTH);

  ecc_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dbl;
  logic [WIDTH-1:0] dbl_plus_a;
  logic [WIDTH-1:0] a_red;

  mod_add_red #(.WIDTH(WIDTH), .P(P)) u_dbl (
    .x_i(acc_q),
    .y_i(acc_q),
    .s_o(dbl)
  );

  mod_add_red #(.WIDTH(WIDTH), .P(P)) u_acc (
    .x_i(dbl),
    .y_i(a_q),
    .s_o(dbl_plus_a)
  );

  // A < 2^WIDTH < 2P, so a single conditional subtract fully reduces it.
  assign a_red = (a_q >= P) ? (a_q - P) : a_q;

`ifdef MOD_MUL_SKIP_ZERO_EN
  logic [IW-1:0] msb_idx;

  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b_q[i]) msb_idx = IW'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          state_d = LOAD;
        end
      end
      LOAD: begin
        a_d     = a_red;
        acc_d   = '0;
        state_d = RUN;
`ifdef MOD_MUL_SKIP_ZERO_EN
        idx_d = msb_idx;
        if (b_q == '0) state_d = DONE;
`else
        idx_d = IW'(WIDTH - 1);
`endif
      end
      RUN: begin
        acc_d = b_q[idx_q] ? dbl_plus_a : dbl;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        // Result and done are registered out of this state; a new start overlaps it.
        r_d    = acc_q;
        done_d = 1'b1;
        if (start) begin
          a_d     = A;
          b_d     = B;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == LOAD) || (state_q == RUN);
  assign done  = done_q;
  assign R     = r_q;

endmodule

// File: tb/tb_mod_mul_serial.sv
// tb/tb_mod_mul_serial.sv - directed-vector bench for mod_mul_serial
module tb_mod_mul_serial;

  localparam logic [255:0] P_C =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] GX_C =
    256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] A;
  logic [255:0] B;
  logic         ready;
  logic         busy;
  logic         done;
  logic [255:0] R;

  int n_vec = 0;
  int n_bad = 0;

  mod_mul_serial dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .ready(ready),
    .busy (busy),
    .done (done),
    .R    (R)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [255:0] b);
`ifdef MOD_MUL_SKIP_ZERO_EN
    if (b == '0) return 2;
    for (int i = 255; i >= 0; i--) begin
      if (b[i]) return i + 3;
    end
    return 2;
`else
    return 258;
`endif
  endfunction

  task automatic start_op(input logic [255:0] a, input logic [255:0] b);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; optionally pokes start mid-run.
  task automatic wait_done(input string tag, input logic [255:0] exp_r, input int exp_l,
                           input int poke_at);
    int           cnt;
    logic [255:0] r0;
    bit           hold_ok;
    bit           hs_ok;
    r0      = R;
    hold_ok = 1'b1;
    hs_ok   = 1'b1;
    cnt     = 0;
    while (cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (poke_at != 0 && start) start = 1'b0;
      if (done) break;
      if (R !== r0) hold_ok = 1'b0;
      if (cnt < exp_l - 1 && (ready !== 1'b0 || busy !== 1'b1)) hs_ok = 1'b0;
      if (poke_at != 0 && cnt == poke_at) begin
        A     = 256'd5;
        B     = 256'd5;
        start = 1'b1;
      end
    end
    check_vec({tag, "_lat"}, 256'(cnt), 256'(exp_l));
    check_vec({tag, "_R"}, R, exp_r);
    check_vec({tag, "_hold"}, 256'(hold_ok), 256'd1);
    check_vec({tag, "_hs"}, 256'(hs_ok), 256'd1);
  endtask

  initial begin
    int  cnt;
    bit  seen_done;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    check_vec("rst_R", R, 256'd0);
    check_vec("rst_done", 256'(done), 256'd0);
    check_vec("rst_busy", 256'(busy), 256'd0);
    check_vec("rst_ready", 256'(ready), 256'd1);
    rst = 1'b0;

    start_op(256'd2, 256'd3);
    check_vec("load_busy", 256'(busy), 256'd1);
    check_vec("load_ready", 256'(ready), 256'd0);
    wait_done("a2b3", 256'd6, exp_lat(256'd3), 0);

    start_op(P_C - 1, P_C - 1);
    wait_done("pm1sq", 256'd1, exp_lat(P_C - 1), 0);
    start_op(P_C - 1, 256'd2);
    wait_done("pm1x2", P_C - 2, exp_lat(256'd2), 0);
    start_op(P_C, 256'd5);
    wait_done("px5", 256'd0, exp_lat(256'd5), 0);
    start_op(P_C + 1, 256'd7);
    wait_done("pp1x7", 256'd7, exp_lat(256'd7), 0);
    start_op(256'd9, 256'd1);
    wait_done("a9b1", 256'd9, exp_lat(256'd1), 0);
    start_op(256'd3, 256'h80);
    wait_done("a3b80", 256'h180, exp_lat(256'h80), 0);

    // Gx * 1, then B=0 accepted back-to-back while in DONE.
    start_op(GX_C, 256'd1);
    cnt = 0;
    while (cnt < 400 && ready !== 1'b1) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_vec("gx_lat_to_done_state", 256'(cnt + 1), 256'(exp_lat(256'd1)));
    B     = 256'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_vec("gx_done", 256'(done), 256'd1);
    check_vec("gx_R", R, GX_C);
    check_vec("b2b_busy", 256'(busy), 256'd1);
    wait_done("b2b_b0", 256'd0, exp_lat(256'd0), 0);

    // A second start at cycle 100 must not disturb the running product.
    start_op(256'd11, P_C - 1);
    wait_done("ignore", P_C - 11, exp_lat(P_C - 1), 100);

    // Reset at cycle 150 aborts with no done pulse.
    start_op(256'd11, P_C - 1);
    repeat (150) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_vec("abort_R", R, 256'd0);
    check_vec("abort_ready", 256'(ready), 256'd1);
    check_vec("abort_busy", 256'(busy), 256'd0);
    @(negedge clk);
    rst       = 1'b0;
    seen_done = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check_vec("abort_no_done", 256'(seen_done), 256'd0);

    start_op(256'd4, 256'd5);
    wait_done("recover", 256'd20, exp_lat(256'd5), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_mul_serial.md
Name: mod_mul_serial

Overview:
- Bit-serial interleaved modular multiplier: R = (A · B) mod p over the secp256k1 prime p = 2^256 − 2^32 − 977.
- Sits directly downstream of the field subtractor in the point-add/double datapath; consumes differences such as (y2 − y1) and (x2 − x1) and multiplies them by other field operands.
- Uses a start/done handshake and needs one 256-bit reduction step per clock.

Parameters:
- WIDTH, 256, operand and result width in bits.
- P, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, field modulus. Must satisfy 2^(WIDTH−1) < P < 2^WIDTH.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- start, input, 1, request strobe; sampled only when ready=1.
- A, input, WIDTH, multiplicand; any value in 0..2^WIDTH−1.
- B, input, WIDTH, multiplier; any value in 0..2^WIDTH−1.
- ready, output, 1, high in IDLE and DONE.
- busy, output, 1, high in LOAD and RUN.
- done, output, 1, one-cycle pulse when R becomes valid.
- R, output, WIDTH, product mod P; always < P; held until the next accepted start.

Behaviour:
- Reset values, applied immediately on rst: state=IDLE, R=0, done=0, busy=0, ready=1, internal registers (a_reg, b_reg, acc, idx) = 0.
- States:
  - IDLE: start=1 latches A and B, enters LOAD.
  - LOAD, 1 cycle: a_reg = (A ≥ P) ? A − P : A. One subtraction suffices because A < 2P. acc=0, idx=WIDTH−1. Enters RUN.
  - RUN, WIDTH cycles. Each cycle:
    - t = 2·acc, computed 257 bits wide; if t ≥ P then t −= P.
    - If b_reg[idx]=1: u = t + a_reg, computed 257 bits wide; if u ≥ P then u −= P. Otherwise u = t.
    - acc ← u; idx decrements. When idx=0 has been processed, enters DONE.
  - DONE, 1 cycle: R=acc, done=1, ready=1. If start=1 in this cycle it is accepted and the next state is LOAD; otherwise IDLE.
- Latency: start accepted at edge k → done high in the cycle following edge k+WIDTH+2. For WIDTH=256 that is 258 cycles start-to-done.
- Throughput: one product per WIDTH+2 cycles with back-to-back starts.
- start while busy=1 is ignored. No queueing, and A/B changes have no effect after the accepting edge.
- R changes only on entry to DONE and on reset. It is stable through the whole next operation.
- rst mid-operation aborts immediately: done is not asserted and R returns to 0.
- Invariant: acc < P at every RUN edge. All intermediate sums fit in WIDTH+1 bits, and no truncation is permitted before the compare.
- B ≥ P is legal; the result is still (A·B) mod P.

Optional Feature:
MOD_MUL_SKIP_ZERO_EN
- Defined:
  - In LOAD, a priority encoder sets idx to the position of the most-significant 1 of B, skipping leading zero iterations.
  - If B=0, RUN is skipped and DONE with R=0 is entered straight from LOAD; done is high in the cycle following edge k+2.
  - Latency becomes msb(B)+3 cycles.
- Undefined: fixed WIDTH+2 latency for all inputs, with no encoder logic.
- Results are identical either way; only timing differs.

Decomposition:
- Shared package/include ecc_defs: ECC_WIDTH=256, ECC_P constant, state encoding IDLE/LOAD/RUN/DONE.
- The field subtractor and this block both use ECC_P from ecc_defs rather than local copies.
- Sub-module mod_add_red: combinational (X + Y) mod P for X, Y < P, with a 257-bit internal sum and conditional subtract.
  - Instantiated twice in the datapath: once as (acc, acc) for doubling, once as (t, a_reg) for accumulation.

Test Plan:
- A=2, B=3, start for 1 cycle → done exactly 258 cycles later, R=6; ready low and busy high in between.
- A=P−1, B=P−1 → R=1. A=P−1, B=2 → R=P−2 (0x…FFFFFC2D).
- A=P (unreduced), B=5 → R=0. A=P+1, B=7 → R=7.
- A=Gx=0x79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798, B=1 → R=Gx. Then, back-to-back with start held high in DONE, B=0 → R=0 with done pulses 258 cycles apart (macro undefined).
- Start pulsed again at cycle 100 of a run with different A/B → ignored; the original product is returned at cycle 258. Assert rst at cycle 150 of a run → R=0 and ready=1 immediately, no done pulse.
- MOD_MUL_SKIP_ZERO_EN defined: B=0 → done 2 cycles after accept, R=0. B=1, A=9 → done 3 cycles after accept, R=9. B=0x80, A=3 → done 10 cycles after accept, R=0x180.
